// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, the default
// limit on consecutive LSB grants, and LSB opcode class decoding.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_LS = 2'd2,
    ST_DRAIN  = 2'd3
  } arb_state_e;

  localparam int MAX_LSB_RUN_DEF = 4;

  localparam logic [2:0] OP_CLASS_STORE = 3'b111;

  // Stores are identified by the top three opcode bits.
  function automatic logic op_is_store(input logic [5:0] op);
    return op[5:3] == OP_CLASS_STORE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory engine between instruction-fetch misses and
// LSB accesses, bounding how long LSB traffic may starve a pending fetch.
//
// state   | meaning
// IDLE    | no grant; picks the next requester
// GNT_IF  | fetch granted, waiting for engine completion
// GNT_LS  | LSB access granted, waiting for engine completion
// DRAIN   | one dead cycle after a flush so the engine can settle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_LSB_RUN = MAX_LSB_RUN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  input  logic        lsb_req,
  input  logic        lsb_is_store,
  output logic        lsb_done,
  output logic        me_ic_valid,
  output logic [31:0] me_ic_addr,
  input  logic        me_ic_done,
  output logic        me_lsb_valid,
  input  logic        me_lsb_done,
  output logic        busy
);

  localparam logic [2:0] RUN_MAX = 3'(MAX_LSB_RUN);

  arb_state_e  state_q, state_d;
  logic [2:0]  run_cnt_q, run_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        store_q, store_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= 3'd0;
      addr_q    <= 32'd0;
      store_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ic_done   = 1'b0;
    lsb_done  = 1'b0;

    // Done pulses are gated by rst so a reset mid-grant never reports completion.
    if (!rst && rdy) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ic_req) run_cnt_d = 3'd0;
          if (!clear) begin
            if (lsb_req && !(ic_req && run_cnt_q == RUN_MAX)) begin
              state_d = ST_GNT_LS;
              store_d = lsb_is_store;
              if (ic_req && run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + 3'd1;
            end else if (ic_req) begin
              state_d   = ST_GNT_IF;
              addr_d    = ic_addr;
              run_cnt_d = 3'd0;
            end
          end
        end
        ST_GNT_IF: begin
          if (clear) begin
            state_d = ST_DRAIN;
          end else if (!ic_req) begin
            state_d = ST_IDLE;
          end else if (me_ic_done) begin
            ic_done = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GNT_LS: begin
          // A store latched at grant is already committed and must complete.
          if (clear && !store_q) begin
            state_d = ST_DRAIN;
          end else if (!lsb_req) begin
            state_d = ST_IDLE;
          end else if (me_lsb_done) begin
            lsb_done = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_DRAIN: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign me_ic_valid  = (state_q == ST_GNT_IF);
  assign me_lsb_valid = (state_q == ST_GNT_LS);
  assign me_ic_addr   = addr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
